prog_loader: RTL and testbench

Synthesizable program loader and run supervisor for the CPU/memory subsystem. It receives a program image as an 8-bit valid/ready byte stream and packs little-endian bytes into DATA_WIDTH-bit words. It writes those words to consecutive memory addresses from 0, holding the CPU in reset throughout. It then releases the CPU, counts run cycles until `end_program` or a timeout, and halts the CPU again.

---
 rtl/prog_loader.sv | 201 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program image loader and CPU run supervisor
//
// Purpose:
//   Packs a little-endian byte stream into DATA_WIDTH-bit words and writes
//   them to memory from word address 0 while the CPU is held in reset. It
//   then releases the CPU, counts run cycles until end_program_i or the
//   optional MAX_CYCLES timeout, and halts the CPU again.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i, len_i        start pulse and word count (sampled in IDLE/DONE)
//   s_data_i/s_valid_i/s_ready_o   image byte stream (valid/ready)
//   mem_sel_o             loader owns the memory port
//   mem_addr_o/mem_value_o/mem_enable_o/mem_wr_en_o   registered write port
//   cpu_rst_o             CPU reset, active-high
//   end_program_i         CPU end-of-program flag
//   done_o/timeout_o/cycles_o      run result
module prog_loader #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16,
   parameter int CYC_WIDTH  = 32,
   parameter int MAX_CYCLES = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH:0]   len_i,
   input  logic [7:0]            s_data_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   output logic                  mem_sel_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_value_o,
   output logic                  mem_enable_o,
   output logic                  mem_wr_en_o,
   output logic                  cpu_rst_o,
   input  logic                  end_program_i,
   output logic                  done_o,
   output logic                  timeout_o,
   output logic [CYC_WIDTH-1:0]  cycles_o
);

   localparam int BPW    = DATA_WIDTH / 8;
   localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

   localparam logic [ADDR_WIDTH:0]  DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(BPW - 1);
   localparam logic [CYC_WIDTH-1:0] MAX_C     = CYC_WIDTH'(MAX_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH:0]     idx_q, idx_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [DATA_WIDTH-1:0]   asm_q, asm_d;
   logic                    wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   value_q, value_d;
   logic [CYC_WIDTH-1:0]    cycles_q, cycles_d;
   logic                    done_q, done_d;
   logic                    timeout_q, timeout_d;

   logic [DATA_WIDTH-1:0]   asm_next;
   logic [CYC_WIDTH-1:0]    cycles_inc;
   logic [ADDR_WIDTH:0]     idx_inc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         lane_q    <= '0;
         asm_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         value_q   <= '0;
         cycles_q  <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         lane_q    <= lane_d;
         asm_q     <= asm_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         value_q   <= value_d;
         cycles_q  <= cycles_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      lane_d    = lane_q;
      asm_d     = asm_q;
      wr_d      = 1'b0;
      addr_d    = '0;
      value_d   = '0;
      cycles_d  = cycles_q;
      done_d    = done_q;
      timeout_d = timeout_q;

      s_ready_o = 1'b0;
      mem_sel_o = 1'b0;
      cpu_rst_o = 1'b1;

      // Word as it will look once the incoming byte lands in its lane; used
      // both for the assembly register and as the write data of a full word.
      asm_next = asm_q;
      for (int l = 0; l < BPW; l++) begin
         if (lane_q == LANE_W'(l)) begin
            asm_next[8*l +: 8] = s_data_i;
         end
      end

      cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
      idx_inc    = idx_q + 1'b1;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               cycles_d  = '0;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               idx_d     = '0;
               lane_d    = '0;
               asm_d     = '0;
               len_d     = (len_i > DEPTH) ? DEPTH : len_i;
               // Clamping never turns a nonzero length into zero.
               state_d   = (len_i != '0) ? S_LOAD : S_RUN;
            end
         end

         S_LOAD: begin
            s_ready_o = 1'b1;
            mem_sel_o = 1'b1;
            if (s_valid_i) begin
               if (lane_q == LAST_LANE) begin
                  wr_d    = 1'b1;
                  addr_d  = idx_q[ADDR_WIDTH-1:0];
                  value_d = asm_next;
                  idx_d   = idx_inc;
                  lane_d  = '0;
                  asm_d   = '0;
                  if (idx_inc == len_q) begin
                     state_d = S_SETTLE;
                  end
               end else begin
                  lane_d = lane_q + 1'b1;
                  asm_d  = asm_next;
               end
            end
         end

         // One cycle so the final write pulse lands while the CPU is still
         // held in reset.
         S_SETTLE: begin
            mem_sel_o = 1'b1;
            state_d   = S_RUN;
         end

         S_RUN: begin
            cpu_rst_o = 1'b0;
            cycles_d  = cycles_inc;
            if (end_program_i) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if ((MAX_CYCLES != 0) && (cycles_inc == MAX_C)) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_addr_o   = addr_q;
   assign mem_value_o  = value_q;
   assign mem_enable_o = wr_q;
   assign mem_wr_en_o  = wr_q;
   assign done_o       = done_q;
   assign timeout_o    = timeout_q;
   assign cycles_o     = cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard testbench for prog_loader
module tb_prog_loader;

   localparam int AW    = 12;
   localparam int DW    = 16;
   localparam int CW    = 32;
   localparam int BPW   = DW / 8;
   localparam int DEPTH = 1 << AW;
   localparam int MAX_T = 8;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic [AW:0]   len_i = '0;
   logic [7:0]    s_data_i = '0;
   logic          s_valid_i = 1'b0;
   logic          end_program_i = 1'b0;

   logic          s_ready0, mem_sel0, mem_en0, wr0, cpu_rst0, done0, to0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] val0;
   logic [CW-1:0] cyc0;
   logic          s_ready1, mem_sel1, mem_en1, wr1, cpu_rst1, done1, to1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] val1;
   logic [CW-1:0] cyc1;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_cnt0 = 0;
   int wr_cnt1 = 0;

   logic [7:0]        tx_q[$];
   logic [AW+DW-1:0]  exp_wr0[$];
   logic [AW+DW-1:0]  exp_wr1[$];
   logic [CW:0]       exp_done0[$];
   logic [CW:0]       exp_done1[$];

   always #5 clk = ~clk;

   prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CYC_WIDTH(CW), .MAX_CYCLES(0)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready0),
      .mem_sel_o(mem_sel0), .mem_addr_o(addr0), .mem_value_o(val0),
      .mem_enable_o(mem_en0), .mem_wr_en_o(wr0), .cpu_rst_o(cpu_rst0),
      .end_program_i(end_program_i), .done_o(done0), .timeout_o(to0), .cycles_o(cyc0));

   prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CYC_WIDTH(CW), .MAX_CYCLES(MAX_T)) dut_t (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready1),
      .mem_sel_o(mem_sel1), .mem_addr_o(addr1), .mem_value_o(val1),
      .mem_enable_o(mem_en1), .mem_wr_en_o(wr1), .cpu_rst_o(cpu_rst1),
      .end_program_i(end_program_i), .done_o(done1), .timeout_o(to1), .cycles_o(cyc1));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Write scoreboards: every write pulse must match the next expected word.
   always @(negedge clk) begin : mon_wr0
      logic [AW+DW-1:0] e;
      if (!rst_i && wr0) begin
         wr_cnt0++;
         check("wr_enable0", mem_en0, 1);
         if (exp_wr0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_unexpected0: got addr 0x%0h data 0x%0h expected no write", addr0, val0);
         end else begin
            e = exp_wr0.pop_front();
            check("wr_addr0", addr0, e[AW+DW-1:DW]);
            check("wr_data0", val0, e[DW-1:0]);
         end
      end
   end

   always @(negedge clk) begin : mon_wr1
      logic [AW+DW-1:0] e;
      if (!rst_i && wr1) begin
         wr_cnt1++;
         if (exp_wr1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_unexpected1: got addr 0x%0h data 0x%0h expected no write", addr1, val1);
         end else begin
            e = exp_wr1.pop_front();
            check("wr_addr1", addr1, e[AW+DW-1:DW]);
            check("wr_data1", val1, e[DW-1:0]);
         end
      end
   end

   // Run-result scoreboards: checked on every rising edge of done_o.
   logic dprev0 = 1'b0;
   logic dprev1 = 1'b0;
   always @(negedge clk) begin : mon_done
      logic [CW:0] e;
      if (done0 && !dprev0) begin
         if (exp_done0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_unexpected0: got cycles %0d expected no done", cyc0);
         end else begin
            e = exp_done0.pop_front();
            check("timeout0", to0, e[CW]);
            check("cycles0", cyc0, e[CW-1:0]);
            check("cpu_rst_done0", cpu_rst0, 1);
         end
      end
      if (done1 && !dprev1) begin
         if (exp_done1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_unexpected1: got cycles %0d expected no done", cyc1);
         end else begin
            e = exp_done1.pop_front();
            check("timeout1", to1, e[CW]);
            check("cycles1", cyc1, e[CW-1:0]);
            check("cpu_rst_done1", cpu_rst1, 1);
         end
      end
      dprev0 = done0;
      dprev1 = done1;
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_rst"}, cpu_rst0, 1);
      check({tag, "_s_ready"}, s_ready0, 0);
      check({tag, "_mem_sel"}, mem_sel0, 0);
      check({tag, "_mem_en"}, mem_en0, 0);
      check({tag, "_wr_en"}, wr0, 0);
      check({tag, "_addr"}, addr0, 0);
      check({tag, "_value"}, val0, 0);
      check({tag, "_done"}, done0, 0);
      check({tag, "_timeout"}, to0, 0);
      check({tag, "_cycles"}, cyc0, 0);
      check({tag, "_cpu_rst_t"}, cpu_rst1, 1);
   endtask

   // Called and returns at a falling edge.
   task automatic start_run(input int len);
      start_i = 1'b1;
      len_i   = (AW+1)'(len);
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic send_stream(input int gap, input bit rnd);
      int t;
      int g;
      foreach (tx_q[i]) begin
         g = rnd ? int'($urandom_range(gap, 0)) : gap;
         s_valid_i = 1'b0;
         repeat (g) @(negedge clk);
         s_valid_i = 1'b1;
         s_data_i  = tx_q[i];
         t = 0;
         while (!s_ready0 && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL byte_accept_timeout: got no s_ready for byte %0d expected s_ready", i);
            s_valid_i = 1'b0;
            return;
         end
         @(negedge clk);
      end
      s_valid_i = 1'b0;
   endtask

   task automatic run_phase(input int e, input bit poke);
      for (int k = 1; k <= e; k++) begin
         start_i       = poke && (k == 1);
         len_i         = (AW+1)'(5);
         end_program_i = (k == e);
         @(negedge clk);
      end
      start_i       = 1'b0;
      end_program_i = 1'b0;
   endtask

   // Full load + run. tx_q must hold min(len, DEPTH)*BPW bytes.
   task automatic do_test(input int len, input int gap, input bit rnd, input int e, input bit poke);
      int nw;
      int w0;
      logic [DW-1:0] word;
      nw = (len > DEPTH) ? DEPTH : len;
      for (int w = 0; w < nw; w++) begin
         word = '0;
         for (int k = 0; k < BPW; k++) word = word | (DW'(tx_q[w*BPW+k]) << (8*k));
         exp_wr0.push_back({AW'(w), word});
         exp_wr1.push_back({AW'(w), word});
      end
      exp_done0.push_back({1'b0, CW'(e)});
      exp_done1.push_back({(e > MAX_T) ? 1'b1 : 1'b0, CW'((e > MAX_T) ? MAX_T : e)});
      w0 = wr_cnt0;
      start_run(len);
      if (nw > 0) begin
         check("ready_after_start", s_ready0, 1);
         check("cpu_rst_load", cpu_rst0, 1);
         send_stream(gap, rnd);
         check("final_wr_pulse", wr0, 1);
         check("ready_after_last", s_ready0, 0);
         check("cpu_rst_settle", cpu_rst0, 1);
         check("mem_sel_settle", mem_sel0, 1);
         @(negedge clk);
         check("cpu_rst_run", cpu_rst0, 0);
         check("mem_sel_run", mem_sel0, 0);
         check("wr_run", wr0, 0);
      end else begin
         check("len0_cpu_rst", cpu_rst0, 0);
         check("len0_ready", s_ready0, 0);
      end
      run_phase(e, poke);
      @(negedge clk);
      check("write_pulses", wr_cnt0 - w0, nw);
      check("wr_queue_drained", exp_wr0.size(), 0);
   endtask

   initial begin
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      check_reset_outputs("idle");

      // Basic image, end_program on the 10th run edge.
      tx_q = '{8'h34, 8'h12, 8'h78, 8'h56};
      do_test(2, 0, 1'b0, 10, 1'b0);

      // Same image with 3-cycle valid gaps; end_program on the 8th edge
      // coincides with the timeout of the MAX_CYCLES=8 instance.
      do_test(2, 3, 1'b0, 8, 1'b0);

      // Empty image; the MAX_CYCLES=8 instance times out first.
      tx_q.delete();
      do_test(0, 0, 1'b0, 20, 1'b0);

      // Reset after one byte of the first word.
      start_run(1);
      s_valid_i = 1'b1;
      s_data_i  = 8'hEE;
      check("ready_before_rst", s_ready0, 1);
      @(negedge clk);
      s_valid_i = 1'b0;
      check("sel_before_rst", mem_sel0, 1);
      #2 rst_i = 1'b1;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      tx_q = '{8'hCD, 8'hAB};
      do_test(1, 0, 1'b0, 4, 1'b0);

      // Randomized images, gaps and run lengths; start_i poked during RUN.
      for (int r = 0; r < 8; r++) begin
         int len;
         len = $urandom_range(6, 0);
         tx_q.delete();
         for (int i = 0; i < len * BPW; i++) tx_q.push_back(8'($urandom));
         do_test(len, 2, 1'b1, int'($urandom_range(14, 1)), 1'b1);
      end

      // Over-long length clamps to the full memory depth.
      tx_q.delete();
      for (int i = 0; i < DEPTH * BPW; i++) tx_q.push_back(8'($urandom));
      do_test(DEPTH + 7, 0, 1'b0, 3, 1'b0);

      repeat (5) @(negedge clk);
      check("exp_wr0_left", exp_wr0.size(), 0);
      check("exp_wr1_left", exp_wr1.size(), 0);
      check("exp_done0_left", exp_done0.size(), 0);
      check("exp_done1_left", exp_done1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish within 100000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
